// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it out one bit per accepted serial beat, streaming words back to back.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             arst_i,
    input  logic             clk_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             ser_o,
    output logic             ser_valid_o,
    input  logic             ser_ready_i,
    output logic             last_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_nx_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nx_s;
    logic             last_s;
    logic             bit_hs_s;
    logic             word_hs_s;
    logic             ready_s;

    // The ready path from ser_ready_i is combinational so a new word can be
    // loaded in the same cycle the previous word's last bit leaves.
    assign last_s       = (state_r == SHIFT) && (cnt_r == CNT_LAST);
    assign bit_hs_s     = (state_r == SHIFT) && ser_ready_i;
    assign ready_s      = !arst_i && ((state_r == IDLE) || (bit_hs_s && last_s));
    assign word_hs_s    = data_valid_i && ready_s;

    assign data_ready_o = ready_s;
    assign ser_valid_o  = (state_r == SHIFT);
    assign last_o       = last_s;
    assign ser_o        = MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0];

    // Shift one position toward the output end, zero filling behind.
    always_comb begin
        shifted_s = sreg_r;
        if (MSB_FIRST) begin
            shifted_s = {sreg_r[WIDTH-2:0], 1'b0};
        end else begin
            shifted_s = {1'b0, sreg_r[WIDTH-1:1]};
        end
    end

    // Next-state logic for the IDLE/SHIFT controller and datapath.
    always_comb begin
        state_nx_s = state_r;
        sreg_nx_s  = sreg_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (word_hs_s) begin
                    state_nx_s = SHIFT;
                    sreg_nx_s  = data_i;
                    cnt_nx_s   = {CW{1'b0}};
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_hs_s && last_s) begin
                    if (word_hs_s) begin
                        state_nx_s = SHIFT;
                        sreg_nx_s  = data_i;
                        cnt_nx_s   = {CW{1'b0}};
                    end else begin
                        state_nx_s = IDLE;
                        sreg_nx_s  = {WIDTH{1'b0}};
                        cnt_nx_s   = {CW{1'b0}};
                    end
                end else if (bit_hs_s) begin
                    sreg_nx_s = shifted_s;
                    cnt_nx_s  = cnt_r + CNT_ONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            default: begin
                state_nx_s = IDLE;
                sreg_nx_s  = {WIDTH{1'b0}};
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, shift register and bit counter; reset discards any partial word.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r <= IDLE;
            sreg_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            sreg_r  <= sreg_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first and an LSB-first instance
// share stimulus and are compared every cycle against a word/bit-index model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         arst;
    logic [W-1:0] data;
    logic         data_valid;
    logic         ser_ready;
    logic         rdy_m, ser_m, sv_m, last_m;
    logic         rdy_l, ser_l, sv_l, last_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .arst_i(arst), .clk_i(clk), .data_i(data), .data_valid_i(data_valid),
        .data_ready_o(rdy_m), .ser_o(ser_m), .ser_valid_o(sv_m),
        .ser_ready_i(ser_ready), .last_o(last_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .arst_i(arst), .clk_i(clk), .data_i(data), .data_valid_i(data_valid),
        .data_ready_o(rdy_l), .ser_o(ser_l), .ser_valid_o(sv_l),
        .ser_ready_i(ser_ready), .last_o(last_l)
    );

    int total = 0;
    int bad   = 0;

    // reference model: the word in flight and the index of the bit on the wire
    logic         m_busy;
    logic [W-1:0] m_word;
    int           m_pos;
    logic         m_acc;

    // observation helpers
    int           vcnt;
    int           rcnt;
    int           nbits;
    logic [15:0]  rx_m;
    logic [15:0]  rx_l;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] stall;
        logic [W-1:0] exp_m;
        logic [W-1:0] exp_l;
        int           exp_cycles;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input bit msb);
        if (!m_busy) return 1'b0;
        return msb ? m_word[W-1-m_pos] : m_word[m_pos];
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_word = '0;
        m_pos  = 0;
    endtask

    task automatic clear_obs();
        vcnt  = 0;
        rcnt  = 0;
        nbits = 0;
        rx_m  = '0;
        rx_l  = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready_m"}, rdy_m, 1'b0);
        chk({tag, "_valid_m"}, sv_m, 1'b0);
        chk({tag, "_ser_m"}, ser_m, 1'b0);
        chk({tag, "_last_m"}, last_m, 1'b0);
        chk({tag, "_ready_l"}, rdy_l, 1'b0);
        chk({tag, "_valid_l"}, sv_l, 1'b0);
        chk({tag, "_ser_l"}, ser_l, 1'b0);
        chk({tag, "_last_l"}, last_l, 1'b0);
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic e_last;
        logic e_rdy;
        @(negedge clk);
        e_last = m_busy && (m_pos == W - 1);
        e_rdy  = !arst && (!m_busy || (ser_ready && e_last));
        chk("ready_m", rdy_m, e_rdy);
        chk("valid_m", sv_m, m_busy);
        chk("ser_m", ser_m, exp_bit(1'b1));
        chk("last_m", last_m, e_last);
        chk("ready_l", rdy_l, e_rdy);
        chk("valid_l", sv_l, m_busy);
        chk("ser_l", ser_l, exp_bit(1'b0));
        chk("last_l", last_l, e_last);
        if (sv_m) vcnt++;
        if (rdy_m) rcnt++;
        if (sv_m && ser_ready) begin
            rx_m = {rx_m[14:0], ser_m};
            nbits++;
        end
        if (sv_l && ser_ready) rx_l = {rx_l[14:0], ser_l};
        @(posedge clk);
        m_acc = 1'b0;
        if (arst) begin
            model_reset();
        end else begin
            if (m_busy && ser_ready) begin
                m_pos++;
                if (m_pos == W) m_busy = 1'b0;
            end
            if (e_rdy && data_valid) begin
                m_word = data;
                m_pos  = 0;
                m_busy = 1'b1;
                m_acc  = 1'b1;
            end
        end
        #1;
    endtask

    // Send one isolated word; stall[i] inserts one ser_ready-low cycle before bit i.
    task automatic send_word(input logic [W-1:0] d, input logic [W-1:0] stall);
        clear_obs();
        data       = d;
        data_valid = 1'b1;
        ser_ready  = 1'b1;
        cycle();
        data_valid = 1'b0;
        data       = W'($urandom);
        for (int i = 0; i < W; i++) begin
            if (stall[i]) begin
                ser_ready = 1'b0;
                cycle();
                ser_ready = 1'b1;
            end
            cycle();
        end
    endtask

    initial begin
        arst       = 1'b1;
        data       = '0;
        data_valid = 1'b0;
        ser_ready  = 1'b0;
        m_acc      = 1'b0;
        model_reset();
        clear_obs();

        // reset values, then release
        #2;
        check_zero_outputs("por");
        @(posedge clk);
        #1;
        arst = 1'b0;
        cycle();

        tbl[0] = '{8'hA5, 8'h00, 8'hA5, 8'hA5, 8};
        tbl[1] = '{8'h01, 8'h00, 8'h01, 8'h80, 8};
        tbl[2] = '{8'hC3, 8'h46, 8'hC3, 8'hC3, 11};
        tbl[3] = '{8'hF0, 8'h00, 8'hF0, 8'h0F, 8};
        tbl[4] = '{8'h12, 8'h81, 8'h12, 8'h48, 10};
        tbl[5] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8};
        tbl[6] = '{8'h00, 8'h10, 8'h00, 8'h00, 9};
        tbl[7] = '{8'h3C, 8'hFF, 8'h3C, 8'h3C, 16};

        for (int k = 0; k < 8; k++) begin
            send_word(tbl[k].d, tbl[k].stall);
            chk("vec_stream_m", rx_m[7:0], tbl[k].exp_m);
            chk("vec_stream_l", rx_l[7:0], tbl[k].exp_l);
            chk("vec_valid_cycles", vcnt, tbl[k].exp_cycles);
            chk("vec_bits", nbits, W);
            cycle();
        end

        // streaming two words with data_valid held high
        clear_obs();
        data       = 8'hF0;
        data_valid = 1'b1;
        ser_ready  = 1'b1;
        cycle();
        data = 8'h0F;
        rcnt = 0;
        repeat (8) cycle();
        chk("stream_ready_pulse", rcnt, 1);
        data_valid = 1'b0;
        repeat (8) cycle();
        chk("stream_m", rx_m, 16'hF00F);
        chk("stream_l", rx_l, 16'h0FF0);
        chk("stream_no_bubble", vcnt, 16);
        cycle();

        // reset in the middle of a word
        clear_obs();
        data       = 8'hFF;
        data_valid = 1'b1;
        ser_ready  = 1'b1;
        cycle();
        data_valid = 1'b0;
        repeat (3) cycle();
        #2;
        arst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        cycle();
        arst = 1'b0;
        cycle();
        send_word(8'h81, 8'h00);
        chk("after_rst_m", rx_m[7:0], 8'h81);
        chk("after_rst_l", rx_l[7:0], 8'h81);
        chk("after_rst_bits", nbits, W);
        cycle();

        // randomized traffic against the model
        data_valid = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!data_valid) begin
                data_valid = 1'($urandom_range(0, 1));
                data       = W'($urandom);
            end
            ser_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (m_acc) data_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
